alu_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer driving the datapath ALU from the initiator side.

---
 rtl/alu_bist_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_alu_bist_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bist_ctrl.sv
// -----------------------------------------------------------------------------
// alu_bist_ctrl
//   Built-in self-test sequencer for the combinational datapath ALU.
//   A loadable table holds {BusA, BusB, ALUCtrl, expected {Zero,BusW}} vectors.
//   On Start each vector is driven onto the ALU operand buses. After a settle
//   window the ALU result is compared against the expected value. Passes are
//   counted, and the first mismatch is recorded.
//
// Ports
//   CLK, Reset           clock (rising edge), asynchronous active-high reset
//   Start                begin a run (honoured in IDLE/DONE only)
//   VecWE, VecAddr,
//   VecA/VecB/VecCtrl/
//   VecExp               vector table write port (honoured in IDLE/DONE only)
//   NumVecWE, NumVecIn   vector count load; saturates to DEPTH
//   BusW, Zero           ALU result and zero flag
//   BusA, BusB, ALUCtrl  registered ALU operands / control code
//   Busy, Done           run in progress / run finished
//   AllPassed            every vector matched (valid while Done)
//   PassCount            matching vectors in the current or last run
//   FailValid, FailIndex,
//   FailActual           first-mismatch record
// -----------------------------------------------------------------------------
module alu_bist_ctrl #(
   parameter int ADDR_W        = 5,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              Start,
   input  logic              VecWE,
   input  logic [ADDR_W-1:0] VecAddr,
   input  logic [31:0]       VecA,
   input  logic [31:0]       VecB,
   input  logic [3:0]        VecCtrl,
   input  logic [32:0]       VecExp,
   input  logic              NumVecWE,
   input  logic [ADDR_W:0]   NumVecIn,
   input  logic [31:0]       BusW,
   input  logic              Zero,
   output logic [31:0]       BusA,
   output logic [31:0]       BusB,
   output logic [3:0]        ALUCtrl,
   output logic              Busy,
   output logic              Done,
   output logic              AllPassed,
   output logic [ADDR_W:0]   PassCount,
   output logic              FailValid,
   output logic [ADDR_W-1:0] FailIndex,
   output logic [32:0]       FailActual
);

   localparam int            DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
   // The wait counter only ever holds SETTLE_CYCLES-1 down to 0.
   localparam int            CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_CHECK,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  ctrl;
      logic [32:0] exp;
   } vecEntry_t;

   vecEntry_t         vecTable [DEPTH];
   vecEntry_t         curVec;

   state_t            state;
   state_t            nextState;
   logic [ADDR_W:0]   numVec;
   logic [ADDR_W-1:0] idx;
   logic [CNT_W-1:0]  waitCnt;

   logic              idle;
   logic              startRun;
   logic              isMatch;
   logic              lastVec;
   logic [ADDR_W:0]   passNext;

   assign idle     = (state == S_IDLE) || (state == S_DONE);
   assign startRun = idle && Start;
   assign curVec   = vecTable[idx];
   assign isMatch  = ({Zero, BusW} == curVec.exp);
   assign lastVec  = ({1'b0, idx} == (numVec - (ADDR_W + 1)'(1)));
   assign passNext = PassCount + (ADDR_W + 1)'(isMatch);

   assign Busy = (state == S_LOAD) || (state == S_WAIT) || (state == S_CHECK);
   assign Done = (state == S_DONE);

   // NOTE: the vector table has no reset; its contents survive Reset so a
   // board can be re-tested without reloading it, and it maps onto plain RAM.
   always_ff @(posedge CLK) begin
      if (VecWE && idle) begin
         vecTable[VecAddr] <= '{a: VecA, b: VecB, ctrl: VecCtrl, exp: VecExp};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // NOTE: nextState gets its default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      nextState = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (Start) begin
               nextState = (numVec == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD:  nextState = S_WAIT;
         S_WAIT:  if (waitCnt == '0) nextState = S_CHECK;
         S_CHECK: nextState = lastVec ? S_DONE : S_LOAD;
         default: nextState = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         numVec     <= '0;
         idx        <= '0;
         waitCnt    <= '0;
         BusA       <= '0;
         BusB       <= '0;
         ALUCtrl    <= '0;
         AllPassed  <= 1'b0;
         PassCount  <= '0;
         FailValid  <= 1'b0;
         FailIndex  <= '0;
         FailActual <= '0;
      end else begin
         if (idle && NumVecWE) begin
            numVec <= (NumVecIn > DEPTH_V) ? DEPTH_V : NumVecIn;
         end

         if (startRun) begin
            idx        <= '0;
            PassCount  <= '0;
            FailValid  <= 1'b0;
            FailIndex  <= '0;
            FailActual <= '0;
            // An empty run goes straight to DONE, where it trivially passes.
            AllPassed  <= (numVec == '0);
         end

         unique case (state)
            S_LOAD: begin
               BusA    <= curVec.a;
               BusB    <= curVec.b;
               ALUCtrl <= curVec.ctrl;
               waitCnt <= CNT_W'(SETTLE_CYCLES - 1);
            end
            S_WAIT: begin
               if (waitCnt != '0) begin
                  waitCnt <= waitCnt - CNT_W'(1);
               end
            end
            S_CHECK: begin
               PassCount <= passNext;
               if (!isMatch && !FailValid) begin
                  FailValid  <= 1'b1;
                  FailIndex  <= idx;
                  FailActual <= {Zero, BusW};
               end
               if (lastVec) begin
                  AllPassed <= (passNext == numVec);
               end else begin
                  idx <= idx + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_bist_ctrl
//   Self-checking bench for alu_bist_ctrl. A behavioural ALU closes the loop,
//   and a reference model predicts each run's outcome. The model walks the
//   mirrored vector table with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_bist_ctrl;

   localparam int ADDR_W = 5;
   localparam int SETTLE = 4;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int PER    = SETTLE + 2;

   logic              CLK = 1'b0;
   logic              Reset;
   logic              Start;
   logic              VecWE;
   logic [ADDR_W-1:0] VecAddr;
   logic [31:0]       VecA;
   logic [31:0]       VecB;
   logic [3:0]        VecCtrl;
   logic [32:0]       VecExp;
   logic              NumVecWE;
   logic [ADDR_W:0]   NumVecIn;
   logic [31:0]       BusW;
   logic              Zero;
   logic [31:0]       BusA;
   logic [31:0]       BusB;
   logic [3:0]        ALUCtrl;
   logic              Busy;
   logic              Done;
   logic              AllPassed;
   logic [ADDR_W:0]   PassCount;
   logic              FailValid;
   logic [ADDR_W-1:0] FailIndex;
   logic [32:0]       FailActual;

   int checks   = 0;
   int failures = 0;

   // Mirror of what the table and count should hold.
   logic [31:0] mA [DEPTH];
   logic [31:0] mB [DEPTH];
   logic [3:0]  mC [DEPTH];
   logic [32:0] mE [DEPTH];
   int          mNum = 0;

   alu_bist_ctrl #(.ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .VecWE(VecWE), .VecAddr(VecAddr),
      .VecA(VecA), .VecB(VecB), .VecCtrl(VecCtrl), .VecExp(VecExp),
      .NumVecWE(NumVecWE), .NumVecIn(NumVecIn), .BusW(BusW), .Zero(Zero),
      .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .Busy(Busy), .Done(Done),
      .AllPassed(AllPassed), .PassCount(PassCount), .FailValid(FailValid),
      .FailIndex(FailIndex), .FailActual(FailActual)
   );

   always #5 CLK = ~CLK;

   // Behavioural ALU: returns {Zero, BusW}.
   function automatic logic [32:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
      logic [31:0] w;
      case (c)
         4'd0:        w = a & b;
         4'd1:        w = a | b;
         4'd2, 4'd8:  w = a + b;
         4'd6, 4'd9:  w = a - b;
         4'd10:       w = a ^ b;
         4'd12:       w = ~(a | b);
         default:     w = a;
      endcase
      return {(w == 32'd0), w};
   endfunction

   always_comb {Zero, BusW} = aluRef(BusA, BusB, ALUCtrl);

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic writeVec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] c, input logic [32:0] e);
      @(negedge CLK);
      VecWE = 1'b1; VecAddr = ADDR_W'(i); VecA = a; VecB = b; VecCtrl = c; VecExp = e;
      @(negedge CLK);
      VecWE = 1'b0;
      mA[i] = a; mB[i] = b; mC[i] = c; mE[i] = e;
   endtask

   task automatic loadNum(input int n);
      @(negedge CLK);
      NumVecWE = 1'b1; NumVecIn = (ADDR_W + 1)'(n);
      @(negedge CLK);
      NumVecWE = 1'b0;
      mNum = (n > DEPTH) ? DEPTH : n;
   endtask

   // Returns #1 after the edge that samples Start (edge t0).
   task automatic startRun();
      @(negedge CLK);
      Start = 1'b1;
      @(posedge CLK);
      #1 Start = 1'b0;
   endtask

   // Follows a run to DONE, checking the bus schedule every cycle, then
   // compares the result registers with the model. pokeAt >= 0 issues a
   // Start plus a corrupting table write while the run is busy.
   task automatic waitDone(input string tag, input int pokeAt);
      int          cnt     = 0;
      int          busErr  = 0;
      int          n       = mNum;
      int          k;
      int          expPass = 0;
      logic        expFv   = 1'b0;
      int          expFi   = 0;
      logic [32:0] expFa   = '0;
      logic [32:0] act;
      while (!Done && cnt < 2000) begin
         if (cnt == pokeAt) begin
            Start = 1'b1; VecWE = 1'b1; VecAddr = '0;
            VecA = ~mA[0]; VecB = 32'h1234; VecCtrl = 4'd1; VecExp = ~mE[0];
         end
         @(posedge CLK);
         #1 Start = 1'b0;
         VecWE = 1'b0;
         cnt++;
         if (n > 0) begin
            k = (cnt - 1) / PER;
            if (k > n - 1) k = n - 1;
            if ({BusA, BusB, ALUCtrl} !== {mA[k], mB[k], mC[k]}) busErr++;
            if (!Done && Busy !== 1'b1) busErr++;
         end
      end
      for (int i = 0; i < n; i++) begin
         act = aluRef(mA[i], mB[i], mC[i]);
         if (act == mE[i]) expPass++;
         else if (!expFv) begin
            expFv = 1'b1; expFi = i; expFa = act;
         end
      end
      check({tag, "_latency"},   cnt,        n * PER);
      check({tag, "_bus"},       busErr,     0);
      check({tag, "_done"},      {Busy, Done}, 2'b01);
      check({tag, "_pass"},      PassCount,  expPass);
      check({tag, "_allpassed"}, AllPassed,  (expPass == n));
      check({tag, "_failvalid"}, FailValid,  expFv);
      check({tag, "_failindex"}, FailIndex,  expFi);
      check({tag, "_failactual"}, FailActual, expFa);
   endtask

   function automatic logic [115:0] allOutputs();
      return {BusA, BusB, ALUCtrl, Busy, Done, AllPassed, PassCount,
              FailValid, FailIndex, FailActual};
   endfunction

   initial begin
      logic [67:0] busSnap;
      int          n;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  c;
      logic [32:0] e;
      logic [3:0]  ops [7];

      ops = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10, 4'd12};
      Reset = 1'b1; Start = 1'b0; VecWE = 1'b0; VecAddr = '0; VecA = '0; VecB = '0;
      VecCtrl = '0; VecExp = '0; NumVecWE = 1'b0; NumVecIn = '0;
      #12;
      check("reset_outputs", allOutputs(), '0);
      @(negedge CLK);
      Reset = 1'b0;

      // T1 / T3: three passing vectors, bus schedule checked each cycle.
      writeVec(0, 32'h000000FF, 32'h00000001, 4'd8,  33'h000000100);
      writeVec(1, 32'h00000001, 32'h00000001, 4'd9,  33'h100000000);
      writeVec(2, 32'hF0F0F0F0, 32'h0000FFFF, 4'd10, 33'h0F0F00F0F);
      loadNum(3);
      startRun();
      waitDone("t1", -1);

      // T2: vector 1 expects the wrong value.
      writeVec(1, 32'h00000001, 32'h00000001, 4'd9, 33'h000000000);
      startRun();
      waitDone("t2", -1);
      check("t2_failactual_lit", FailActual, 33'h100000000);

      // T6: fix vector 1, rerun from DONE with Start/VecWE poked while busy.
      writeVec(1, 32'h00000001, 32'h00000001, 4'd9, 33'h100000000);
      startRun();
      waitDone("t6_rerun", 3);
      startRun();
      waitDone("t6_table_kept", -1);

      // T4: empty run finishes at t0 and leaves the operands alone.
      loadNum(0);
      busSnap = {BusA, BusB, ALUCtrl};
      startRun();
      waitDone("t4", -1);
      check("t4_bus_held", {BusA, BusB, ALUCtrl}, busSnap);

      // T5: reset during vector 1 WAIT, then reload the count only.
      loadNum(3);
      startRun();
      repeat (8) @(posedge CLK);
      #3 Reset = 1'b1;
      #1 check("t5_async_reset", allOutputs(), '0);
      @(negedge CLK);
      Reset = 1'b0;
      mNum = 0;
      startRun();
      waitDone("t5_numvec_cleared", -1);
      loadNum(3);
      startRun();
      waitDone("t5_rerun", -1);

      // Count saturation: 45 requested, the full table of 32 runs.
      for (int i = 0; i < DEPTH; i++) begin
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : $urandom();
         c = ops[$urandom_range(0, 6)];
         writeVec(i, a, b, c, aluRef(a, b, c));
      end
      loadNum(45);
      startRun();
      waitDone("sat", -1);

      // Random runs with occasional corrupted expectations.
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            c = ops[$urandom_range(0, 6)];
            e = aluRef(a, b, c);
            if ($urandom_range(0, 3) == 0) e[$urandom_range(0, 32)] ^= 1'b1;
            writeVec(i, a, b, c, e);
         end
         loadNum(n);
         startRun();
         waitDone($sformatf("rand%0d", r), -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
